// File: rtl/rob_gen2.sv
// Reorder buffer: in-order dispatch, multi-port writeback, up to RETIRE_W in-order retirements per cycle.
// Optional feature: define ROB_FLUSH_EN to add the flush port (flush beats dispatch, writeback and retire).
module rob_gen2 #(
  parameter int DEPTH    = 64,
  parameter int WB_PORTS = 3,
  parameter int RETIRE_W = 2,
  parameter int PREG_W   = 6,
  parameter int PC_W     = 12,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef ROB_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [PREG_W-1:0]            disp_rd,
  input  logic [PREG_W-1:0]            disp_rd_old,
  input  logic [PC_W-1:0]              disp_pc,
  output logic [TAG_W-1:0]             disp_tag,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
  output logic [RETIRE_W-1:0]          ret_valid,
  output logic [RETIRE_W*PREG_W-1:0]   ret_rd,
  output logic [RETIRE_W*PREG_W-1:0]   ret_rd_old,
  output logic [RETIRE_W*DATA_W-1:0]   ret_data,
  output logic [RETIRE_W*PC_W-1:0]     ret_pc,
  output logic [TAG_W:0]               count,
  output logic                         empty,
  output logic                         full
);
  localparam int CW = TAG_W + 1;

  logic [DEPTH-1:0]  valid_q, valid_d, complete_q, complete_d;
  logic [PREG_W-1:0] rd_q [DEPTH];
  logic [PREG_W-1:0] rd_d [DEPTH];
  logic [PREG_W-1:0] rdo_q [DEPTH];
  logic [PREG_W-1:0] rdo_d [DEPTH];
  logic [PC_W-1:0]   pc_q [DEPTH];
  logic [PC_W-1:0]   pc_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d, idx, wtag;
  logic [CW-1:0]     count_q, count_d;
  logic              empty_q, full_q, accept, run;
  logic [2:0]        n_ret;
  logic [RETIRE_W-1:0]        ret_valid_q, ret_valid_d;
  logic [RETIRE_W*PREG_W-1:0] ret_rd_q, ret_rd_d, ret_rdo_q, ret_rdo_d;
  logic [RETIRE_W*DATA_W-1:0] ret_data_q, ret_data_d;
  logic [RETIRE_W*PC_W-1:0]   ret_pc_q, ret_pc_d;

  assign disp_ready = !full_q;
  assign disp_tag   = tail_q;
  assign accept     = disp_valid && !full_q;

  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    rd_d       = rd_q;
    rdo_d      = rdo_q;
    pc_d       = pc_q;
    data_d     = data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    ret_valid_d = '0;
    ret_rd_d    = '0;
    ret_rdo_d   = '0;
    ret_data_d  = '0;
    ret_pc_d    = '0;
    n_ret = '0;
    run   = 1'b1;
    idx   = '0;
    wtag  = '0;
    // Ascending port order lets the highest port win a tag collision.
    for (int k = 0; k < WB_PORTS; k++) begin
      wtag = wb_tag[k*TAG_W +: TAG_W];
      if (wb_valid[k] && valid_q[wtag]) begin
        data_d[wtag]     = wb_data[k*DATA_W +: DATA_W];
        complete_d[wtag] = 1'b1;
      end
    end
    // Retire decision uses pre-edge state, so a writeback shows up one edge later.
    for (int i = 0; i < RETIRE_W; i++) begin
      idx = head_q + TAG_W'(i);
      if (run && valid_q[idx] && complete_q[idx]) begin
        ret_valid_d[i]                  = 1'b1;
        ret_rd_d[i*PREG_W +: PREG_W]    = rd_q[idx];
        ret_rdo_d[i*PREG_W +: PREG_W]   = rdo_q[idx];
        ret_data_d[i*DATA_W +: DATA_W]  = data_q[idx];
        ret_pc_d[i*PC_W +: PC_W]        = pc_q[idx];
        valid_d[idx]    = 1'b0;
        complete_d[idx] = 1'b0;
        n_ret = n_ret + 1'b1;
      end else begin
        run = 1'b0;
      end
    end
    if (accept) begin
      valid_d[tail_q]    = 1'b1;
      complete_d[tail_q] = 1'b0;
      rd_d[tail_q]       = disp_rd;
      rdo_d[tail_q]      = disp_rd_old;
      pc_d[tail_q]       = disp_pc;
      data_d[tail_q]     = '0;
      tail_d             = tail_q + 1'b1;
    end
    head_d  = head_q + TAG_W'(n_ret);
    count_d = count_q + CW'(accept) - CW'(n_ret);
`ifdef ROB_FLUSH_EN
    if (flush) begin
      valid_d     = '0;
      complete_d  = '0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      ret_valid_d = '0;
      ret_rd_d    = '0;
      ret_rdo_d   = '0;
      ret_data_d  = '0;
      ret_pc_d    = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      complete_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      ret_valid_q <= '0;
      ret_rd_q    <= '0;
      ret_rdo_q   <= '0;
      ret_data_q  <= '0;
      ret_pc_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      complete_q  <= complete_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      empty_q     <= (count_d == '0);
      full_q      <= (count_d == CW'(DEPTH));
      ret_valid_q <= ret_valid_d;
      ret_rd_q    <= ret_rd_d;
      ret_rdo_q   <= ret_rdo_d;
      ret_data_q  <= ret_data_d;
      ret_pc_q    <= ret_pc_d;
    end
  end

  // Payload is only ever read behind a valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    rdo_q  <= rdo_d;
    pc_q   <= pc_d;
    data_q <= data_d;
  end

  assign ret_valid  = ret_valid_q;
  assign ret_rd     = ret_rd_q;
  assign ret_rd_old = ret_rdo_q;
  assign ret_data   = ret_data_q;
  assign ret_pc     = ret_pc_q;
  assign count      = count_q;
  assign empty      = empty_q;
  assign full       = full_q;
endmodule

// File: tb/tb_rob_gen2.sv
// Directed bench for rob_gen2 with default parameters (DEPTH=64, WB_PORTS=3, RETIRE_W=2).
module tb_rob_gen2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
`ifdef ROB_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic        disp_valid = 1'b0;
  logic        disp_ready;
  logic [5:0]  disp_rd = '0, disp_rd_old = '0;
  logic [11:0] disp_pc = '0;
  logic [5:0]  disp_tag;
  logic [2:0]  wb_valid = '0;
  logic [17:0] wb_tag = '0;
  logic [95:0] wb_data = '0;
  logic [1:0]  ret_valid;
  logic [11:0] ret_rd, ret_rd_old;
  logic [63:0] ret_data;
  logic [23:0] ret_pc;
  logic [6:0]  count;
  logic        empty, full;

  int total = 0, passes = 0, nret = 0;

  rob_gen2 dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd),
    .disp_rd_old(disp_rd_old), .disp_pc(disp_pc), .disp_tag(disp_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_rd_old(ret_rd_old),
    .ret_data(ret_data), .ret_pc(ret_pc), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [11:0] pc, input logic [5:0] rd, input logic [5:0] rdo);
    disp_valid = 1'b1; disp_pc = pc; disp_rd = rd; disp_rd_old = rdo;
    step();
    disp_valid = 1'b0;
  endtask

  task automatic wb1(input int port, input int tag, input logic [31:0] data);
    logic [5:0] t;
    t = 6'(tag);
    wb_valid[port] = 1'b1;
    wb_tag[port*6 +: 6] = t;
    wb_data[port*32 +: 32] = data;
  endtask

  task automatic wb_clear();
    wb_valid = '0; wb_tag = '0; wb_data = '0;
  endtask

  task automatic collect();
    for (int s = 0; s < 2; s++)
      if (ret_valid[s]) begin
        chk("wrap_pc", 64'(ret_pc[s*12 +: 12]), 64'(12'h200 + nret));
        nret++;
      end
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_count", 64'(count), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_full", 64'(full), 0);
    chk("rst_ready", 64'(disp_ready), 1);
    chk("rst_retv", 64'(ret_valid), 0);
    chk("rst_tag", 64'(disp_tag), 0);
    step();
    rst_n = 1'b1;

    // in-order retire with out-of-order writeback
    disp(12'h100, 6'd1, 6'd10);
    disp(12'h101, 6'd2, 6'd11);
    disp(12'h102, 6'd3, 6'd12);
    chk("io_count", 64'(count), 3);
    chk("io_tag", 64'(disp_tag), 3);
    wb1(0, 2, 32'hA2); step(); wb_clear();
    chk("io_wb2_noret", 64'(ret_valid), 0);
    wb1(1, 1, 32'hA1); step(); wb_clear();
    chk("io_wb1_noret", 64'(ret_valid), 0);
    wb1(2, 0, 32'hA0); step(); wb_clear();
    chk("io_wb0_noret", 64'(ret_valid), 0);
    step();
    chk("io_retv01", 64'(ret_valid), 2'b11);
    chk("io_pc01", 64'(ret_pc), 24'h101100);
    chk("io_data01", ret_data, 64'h000000A1_000000A0);
    chk("io_rd01", 64'(ret_rd), {6'd2, 6'd1});
    chk("io_rdo01", 64'(ret_rd_old), {6'd11, 6'd10});
    step();
    chk("io_retv2", 64'(ret_valid), 2'b01);
    chk("io_pc2", 64'(ret_pc), 24'h000102);
    step();
    chk("io_retv_idle", 64'(ret_valid), 0);
    chk("io_empty", 64'(empty), 1);

    // writeback port conflict on tag 5
    disp(12'h010, 6'd4, 6'd0);
    disp(12'h011, 6'd5, 6'd0);
    disp(12'h012, 6'd6, 6'd0);
    wb1(0, 5, 32'h11); wb1(1, 3, 32'h33); wb1(2, 5, 32'h22); step(); wb_clear();
    chk("pc_noret", 64'(ret_valid), 0);
    wb1(1, 4, 32'h44); step(); wb_clear();
    chk("pc_retv3", 64'(ret_valid), 2'b01);
    chk("pc_data3", 64'(ret_data[31:0]), 32'h33);
    step();
    chk("pc_retv45", 64'(ret_valid), 2'b11);
    chk("pc_data45", ret_data, 64'h00000022_00000044);
    chk("pc_count", 64'(count), 0);

    // full: tail/head at 6
    for (int i = 0; i < 64; i++) disp(12'(i), 6'd0, 6'd0);
    chk("full_full", 64'(full), 1);
    chk("full_count", 64'(count), 64);
    chk("full_ready", 64'(disp_ready), 0);
    chk("full_empty", 64'(empty), 0);
    disp(12'hFFF, 6'd0, 6'd0);
    chk("full_65_count", 64'(count), 64);
    chk("full_65_tag", 64'(disp_tag), 6);
    wb1(0, 6, 32'h5); step(); wb_clear();
    chk("full_ready_wb", 64'(disp_ready), 0);
    step();
    chk("full_ret1", 64'(ret_valid), 2'b01);
    chk("full_ret1_pc", 64'(ret_pc[11:0]), 0);
    chk("full_count63", 64'(count), 63);
    chk("full_ready_after", 64'(disp_ready), 1);
    // async reset pulse between edges clears registered outputs immediately
    rst_n = 1'b0;
    #1;
    chk("ar_retv", 64'(ret_valid), 0);
    chk("ar_count", 64'(count), 0);
    chk("ar_full", 64'(full), 0);
    chk("ar_tag", 64'(disp_tag), 0);
    #1 rst_n = 1'b1;

    // wrap: 100 dispatch/writeback pairs
    for (int i = 0; i < 100; i++) begin
      chk("wrap_tag", 64'(disp_tag), 64'(i % 64));
      disp_valid = 1'b1; disp_pc = 12'(12'h200 + i);
      wb_clear();
      if (i > 0) wb1(0, (i - 1) % 64, 32'(i));
      step(); collect();
    end
    disp_valid = 1'b0;
    wb_clear(); wb1(0, 99 % 64, 32'h0); step(); collect(); wb_clear();
    for (int c = 0; c < 40 && count != 0; c++) begin step(); collect(); end
    step(); collect();
    chk("wrap_count", 64'(count), 0);
    chk("wrap_nret", 64'(nret), 100);
    chk("wrap_tag_end", 64'(disp_tag), 36);

    // reset with 7 in flight, 3 of them complete
    for (int i = 0; i < 7; i++) disp(12'(12'h300 + i), 6'd0, 6'd0);
    chk("rs_count7", 64'(count), 7);
    wb1(0, 36, 32'h1); wb1(1, 37, 32'h2); wb1(2, 38, 32'h3); step(); wb_clear();
    #1 rst_n = 1'b0;
    #1;
    chk("rs_count", 64'(count), 0);
    chk("rs_empty", 64'(empty), 1);
    chk("rs_ready", 64'(disp_ready), 1);
    chk("rs_tag", 64'(disp_tag), 0);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rs_noret", 64'(ret_valid), 0);
    end
    chk("rs_count_after", 64'(count), 0);

`ifdef ROB_FLUSH_EN
    for (int i = 0; i < 10; i++) disp(12'(12'h400 + i), 6'd0, 6'd0);
    wb1(0, 1, 32'h1); wb1(1, 2, 32'h2); wb1(2, 3, 32'h3); step(); wb_clear();
    wb1(0, 4, 32'h4); step(); wb_clear();
    chk("fl_count10", 64'(count), 10);
    flush = 1'b1; disp_valid = 1'b1; wb1(0, 0, 32'h9);
    step();
    flush = 1'b0; disp_valid = 1'b0; wb_clear();
    chk("fl_count", 64'(count), 0);
    chk("fl_empty", 64'(empty), 1);
    chk("fl_retv", 64'(ret_valid), 0);
    chk("fl_tag", 64'(disp_tag), 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("fl_noret", 64'(ret_valid), 0);
    end
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
